// File: rtl/sram_stream_reader.sv
// Wishbone burst-read master that streams bytes from the QSPI SRAM controller into a byte FIFO.
// Latency: a byte is on data_o the cycle after its ack; bursts are cut short so the FIFO never overflows.
// Backpressure: ready_i low fills the FIFO, which ends the burst and parks the bus in PAUSE.
module sram_stream_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [23:0]          start_adr_i,
  input  logic [LEN_WIDTH-1:0] length_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [7:0]           data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic [23:0]          adr_o,
  output logic                 we_o,
  output logic [2:0]           cti_o,
  output logic [1:0]           bte_o,
  input  logic                 ack_i,
  input  logic [7:0]           dat_i,
  input  logic                 err_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_PAUSE,
    S_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [23:0]          adr_q, adr_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 cyc_q, cyc_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic [CW-1:0]        fifo_cnt;
  logic [CW-1:0]        free_slots;
  logic [7:0]           fifo_head;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_flush;
  logic                 last_beat;

  // Free-slot count ignores a pop in the same cycle, so the cut-off is conservative.
  assign free_slots = CW'(FIFO_DEPTH) - fifo_cnt;
  assign last_beat  = (rem_q == LEN_WIDTH'(1)) || (free_slots == CW'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= 24'h000000;
      rem_q   <= '0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    rem_d      = rem_q;
    cyc_d      = cyc_q;
    err_d      = err_q;
    done_d     = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (length_i != '0) begin
            adr_d   = start_adr_i;
            rem_d   = length_i;
            err_d   = 1'b0;
            cyc_d   = 1'b1;
            state_d = S_BURST;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_BURST: begin
        if (cyc_q && err_i) begin
          cyc_d      = 1'b0;
          fifo_flush = 1'b1;
          err_d      = 1'b1;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else if (cyc_q && ack_i) begin
          fifo_push = 1'b1;
          adr_d     = adr_q + 24'd1;
          rem_d     = rem_q - 1'b1;
          if (last_beat) begin
            cyc_d   = 1'b0;
            state_d = (rem_q == LEN_WIDTH'(1)) ? S_DRAIN : S_PAUSE;
          end
        end
      end

      S_PAUSE: begin
        // Restart with a fresh address phase once half the FIFO is free.
        if (free_slots >= CW'(FIFO_DEPTH / 2)) begin
          cyc_d   = 1'b1;
          state_d = S_BURST;
        end
      end

      S_DRAIN: begin
        if (fifo_cnt == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  assign fifo_pop = valid_o && ready_i;

  sram_stream_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (fifo_flush),
    .push_i     (fifo_push),
    .push_dat_i (dat_i),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_cnt)
  );

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = done_q;
  assign error_o = err_q;
  assign data_o  = fifo_head;
  assign valid_o = (fifo_cnt != '0);
  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign adr_o   = adr_q;
  assign we_o    = 1'b0;
  assign cti_o   = (cyc_q && !last_beat) ? 3'b010 : 3'b111;
  assign bte_o   = 2'b00;

endmodule

// First-word-fall-through byte FIFO with synchronous flush.
// Latency: a pushed byte is visible at head_o the next cycle, also when pushed into an empty FIFO.
// Backpressure: none internally; pushes into a full FIFO without a pop are dropped and flagged.
module sram_stream_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [7:0]               push_dat_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0);
  assign push_ok = push_i && (!full || pop_ok);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_q] <= push_dat_i;
    end
  end

  no_overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full && !pop_ok));

  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : 8'h00;
  assign count_o = cnt_q;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench: cycle table for the basic and zero-length cases, plus a reactive slave for the rest.
module tb_sram_stream_reader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [23:0] start_adr_i;
  logic [15:0] length_i;
  logic        busy_o, done_o, error_o, valid_o, ready_i;
  logic [7:0]  data_o;
  logic        cyc_o, stb_o, we_o, ack_i, err_i;
  logic [23:0] adr_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic [7:0]  dat_i;

  always #5 clk_i = ~clk_i;

  sram_stream_reader #(
    .FIFO_DEPTH (4),
    .LEN_WIDTH  (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .start_adr_i (start_adr_i),
    .length_i    (length_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .adr_o       (adr_o),
    .we_o        (we_o),
    .cti_o       (cti_o),
    .bte_o       (bte_o),
    .ack_i       (ack_i),
    .dat_i       (dat_i),
    .err_i       (err_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic        slv_en;
  int          err_beat;
  int          nbeat;
  int          npop;
  logic [23:0] beat_adr [0:31];
  logic [2:0]  beat_cti [0:31];
  logic [23:0] exp_rd_adr;

  typedef struct {
    logic        start;
    logic [23:0] sadr;
    logic [15:0] len;
    logic        ack;
    logic [7:0]  dat;
    logic [38:0] exp;   // {busy, done, cyc, cti, adr, valid, data}
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] pat(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic vec_t mk(input logic st, input logic [23:0] sa, input logic [15:0] ln,
                              input logic ak, input logic [7:0] dt,
                              input logic b, input logic d, input logic c, input logic [2:0] ct,
                              input logic [23:0] ad, input logic v, input logic [7:0] dd);
    vec_t r;
    r.start = st;
    r.sadr  = sa;
    r.len   = ln;
    r.ack   = ak;
    r.dat   = dt;
    r.exp   = {b, d, c, ct, ad, v, dd};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: slave reacts to the current bus state, consumer checks the byte it pops.
  task automatic step();
    if (slv_en) begin
      if (cyc_o && stb_o && !ack_i && !err_i) begin
        if (nbeat == err_beat) begin
          err_i = 1'b1;
        end else begin
          ack_i = 1'b1;
          dat_i = pat(adr_o);
          if (nbeat < 32) begin
            beat_adr[nbeat] = adr_o;
            beat_cti[nbeat] = cti_o;
          end
          nbeat++;
        end
      end else begin
        ack_i = 1'b0;
        err_i = 1'b0;
      end
    end
    if (valid_o && ready_i) begin
      check($sformatf("stream@%0h", exp_rd_adr), data_o, pat(exp_rd_adr));
      exp_rd_adr = exp_rd_adr + 24'd1;
      npop++;
    end
    @(negedge clk_i);
  endtask

  task automatic start_req(input logic [23:0] a, input logic [15:0] l);
    start_i     = 1'b1;
    start_adr_i = a;
    length_i    = l;
    step();
    start_i     = 1'b0;
  endtask

  task automatic run_to_done(input string name);
    for (int i = 0; i < 200 && !done_o; i++) step();
    check(name, {done_o, busy_o}, 2'b10);
  endtask

  task automatic new_test(input logic [23:0] a, input logic rdy);
    nbeat      = 0;
    npop       = 0;
    exp_rd_adr = a;
    ready_i    = rdy;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    start_adr_i = 24'h0;
    length_i    = 16'h0;
    ready_i     = 1'b1;
    ack_i       = 1'b0;
    err_i       = 1'b0;
    dat_i       = 8'h00;
    slv_en      = 1'b0;
    err_beat    = -1;
    nbeat       = 0;
    npop        = 0;
    exp_rd_adr  = 24'h0;

    repeat (2) @(negedge clk_i);
    check("reset_state",
          {busy_o, done_o, error_o, valid_o, data_o, cyc_o, stb_o, adr_o, cti_o, we_o, bte_o},
          {4'b0000, 8'h00, 2'b00, 24'h000000, 3'b111, 1'b0, 2'b00});
    rst_i = 1'b0;
    @(negedge clk_i);

    // Basic len=3 burst with ready high, then a zero-length request.
    tbl.push_back(mk(1, 24'h000100, 16'd3, 0, 8'h00, 0, 0, 0, 3'b111, 24'h000000, 0, 8'h00));
    tbl.push_back(mk(0, 24'h0, 16'd0, 0, 8'h00, 1, 0, 1, 3'b010, 24'h000100, 0, 8'h00));
    tbl.push_back(mk(0, 24'h0, 16'd0, 1, 8'hA0, 1, 0, 1, 3'b010, 24'h000100, 0, 8'h00));
    tbl.push_back(mk(0, 24'h0, 16'd0, 0, 8'h00, 1, 0, 1, 3'b010, 24'h000101, 1, 8'hA0));
    tbl.push_back(mk(0, 24'h0, 16'd0, 1, 8'hA1, 1, 0, 1, 3'b010, 24'h000101, 0, 8'h00));
    tbl.push_back(mk(0, 24'h0, 16'd0, 0, 8'h00, 1, 0, 1, 3'b111, 24'h000102, 1, 8'hA1));
    tbl.push_back(mk(0, 24'h0, 16'd0, 1, 8'hA2, 1, 0, 1, 3'b111, 24'h000102, 0, 8'h00));
    tbl.push_back(mk(0, 24'h0, 16'd0, 0, 8'h00, 1, 0, 0, 3'b111, 24'h000103, 1, 8'hA2));
    tbl.push_back(mk(0, 24'h0, 16'd0, 0, 8'h00, 1, 0, 0, 3'b111, 24'h000103, 0, 8'h00));
    tbl.push_back(mk(0, 24'h0, 16'd0, 0, 8'h00, 0, 1, 0, 3'b111, 24'h000103, 0, 8'h00));
    tbl.push_back(mk(0, 24'h0, 16'd0, 0, 8'h00, 0, 0, 0, 3'b111, 24'h000103, 0, 8'h00));
    tbl.push_back(mk(1, 24'h000555, 16'd0, 0, 8'h00, 0, 0, 0, 3'b111, 24'h000103, 0, 8'h00));
    tbl.push_back(mk(0, 24'h0, 16'd0, 0, 8'h00, 0, 1, 0, 3'b111, 24'h000103, 0, 8'h00));
    tbl.push_back(mk(0, 24'h0, 16'd0, 0, 8'h00, 0, 0, 0, 3'b111, 24'h000103, 0, 8'h00));

    ready_i = 1'b1;
    foreach (tbl[i]) begin
      start_i     = tbl[i].start;
      start_adr_i = tbl[i].sadr;
      length_i    = tbl[i].len;
      ack_i       = tbl[i].ack;
      dat_i       = tbl[i].dat;
      check($sformatf("vec%0d", i),
            {25'b0, busy_o, done_o, cyc_o, cti_o, adr_o, valid_o, data_o},
            {25'b0, tbl[i].exp});
      @(negedge clk_i);
    end
    start_i = 1'b0;
    ack_i   = 1'b0;
    slv_en  = 1'b1;

    // Backpressure: 4-deep FIFO fills, burst cut, PAUSE until two slots free.
    new_test(24'h000200, 1'b0);
    start_req(24'h000200, 16'd10);
    repeat (12) step();
    check("bp_beats1", nbeat, 4);
    check("bp_cti_beat3", beat_cti[2], 3'b010);
    check("bp_cti_beat4", beat_cti[3], 3'b111);
    check("bp_adr_beat4", beat_adr[3], 24'h000203);
    check("bp_pause", {busy_o, cyc_o, valid_o}, 3'b101);
    repeat (6) step();
    check("bp_hold_beats", nbeat, 4);
    check("bp_hold_cyc", cyc_o, 1'b0);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    repeat (3) step();
    check("bp_one_free", {nbeat[7:0], cyc_o}, {8'd4, 1'b0});
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    repeat (8) step();
    check("bp_beats2", nbeat, 6);
    check("bp_resume_adr", beat_adr[4], 24'h000204);
    check("bp_resume_cti", {beat_cti[4], beat_cti[5]}, 6'b010_111);
    ready_i = 1'b1;
    run_to_done("bp_done");
    check("bp_count", {nbeat[7:0], npop[7:0]}, {8'd10, 8'd10});
    check("bp_last_adr", beat_adr[9], 24'h000209);

    // 24-bit address wrap.
    new_test(24'hFFFFFE, 1'b1);
    start_req(24'hFFFFFE, 16'd4);
    run_to_done("wrap_done");
    check("wrap_adr0", beat_adr[0], 24'hFFFFFE);
    check("wrap_adr1", beat_adr[1], 24'hFFFFFF);
    check("wrap_adr2", beat_adr[2], 24'h000000);
    check("wrap_adr3", beat_adr[3], 24'h000001);
    check("wrap_cti", {beat_cti[0], beat_cti[3]}, 6'b010_111);
    check("wrap_pops", npop, 4);

    // Slave error on the second beat.
    new_test(24'h000300, 1'b0);
    err_beat = 1;
    start_req(24'h000300, 16'd5);
    for (int i = 0; i < 20 && !err_i; i++) step();
    check("err_reached", {err_i, nbeat[7:0]}, {1'b1, 8'd1});
    check("err_resp", {cyc_o, stb_o, valid_o, busy_o, done_o, error_o}, 6'b000011);
    err_beat = -1;
    step();
    check("err_done_pulse", {done_o, error_o}, 2'b01);
    repeat (3) step();
    check("err_sticky", {error_o, busy_o, cyc_o}, 3'b100);
    new_test(24'h000400, 1'b1);
    start_req(24'h000400, 16'd1);
    check("err_clear", {error_o, busy_o}, 2'b01);
    run_to_done("len1_done");
    check("len1_pops", npop, 1);

    // Start while busy is ignored.
    new_test(24'h000500, 1'b0);
    start_req(24'h000500, 16'd6);
    repeat (3) step();
    start_i     = 1'b1;
    start_adr_i = 24'h000900;
    length_i    = 16'd2;
    step();
    start_i = 1'b0;
    ready_i = 1'b1;
    run_to_done("ign_done");
    check("ign_count", {nbeat[7:0], npop[7:0]}, {8'd6, 8'd6});
    check("ign_adr", {beat_adr[2], beat_adr[5]}, {24'h000502, 24'h000505});

    // Asynchronous reset in the middle of a burst.
    new_test(24'h000600, 1'b0);
    start_req(24'h000600, 16'd6);
    repeat (4) step();
    check("rst_pre", {cyc_o, valid_o, busy_o}, 3'b111);
    slv_en = 1'b0;
    ack_i  = 1'b0;
    rst_i  = 1'b1;
    #1;
    check("rst_async", {cyc_o, stb_o, valid_o, busy_o, data_o, adr_o, cti_o},
          {4'b0000, 8'h00, 24'h000000, 3'b111});
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_idle", {cyc_o, valid_o, busy_o, done_o, error_o}, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
